// File: rtl/bitwise_logic_serial.sv
// Slice-serial AND/OR/XOR/NOR unit with start/busy/done handshake.
// Define LOGIC_ZFLAG_EN to add the Z (result == 0) flag.
module bitwise_logic_serial #(
  parameter int N     = 32,
  parameter int SLICE = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
`ifdef LOGIC_ZFLAG_EN
  output logic         Z,
`endif
  output logic [N-1:0] F
);

  localparam int S  = N / SLICE;
  localparam int CW = (S > 1) ? $clog2(S) : 1;
  localparam logic [CW-1:0] LAST = CW'(S - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic [1:0]     op_q, op_d;
  logic [N-1:0]   f_q, f_d;
  logic [31:0]    base;
  logic [SLICE-1:0] sa, sb, res;
`ifdef LOGIC_ZFLAG_EN
  logic           z_q, z_d;
`endif

  assign base = 32'(cnt_q) * 32'(SLICE);
  assign sa   = a_q[base +: SLICE];
  assign sb   = b_q[base +: SLICE];

  always_comb begin
    res = '0;
    unique case (op_q)
      2'b00: res = sa & sb;
      2'b01: res = sa | sb;
      2'b10: res = sa ^ sb;
      2'b11: res = ~(sa | sb);
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    f_d     = f_q;
`ifdef LOGIC_ZFLAG_EN
    z_d     = z_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          op_d    = op;
          f_d     = '0;
          cnt_d   = '0;
          state_d = RUN;
`ifdef LOGIC_ZFLAG_EN
          z_d     = 1'b0;
`endif
        end
      end
      RUN: begin
        f_d[base +: SLICE] = res;
`ifdef LOGIC_ZFLAG_EN
        z_d = (res == '0) && (cnt_q == '0 || z_q);
`endif
        if (cnt_q == LAST) state_d = DONE;
        else cnt_d = cnt_q + 1'b1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      f_q     <= '0;
`ifdef LOGIC_ZFLAG_EN
      z_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      f_q     <= f_d;
`ifdef LOGIC_ZFLAG_EN
      z_q     <= z_d;
`endif
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign F    = f_q;
`ifdef LOGIC_ZFLAG_EN
  assign Z    = z_q;
`endif

endmodule
